// File: rtl/dwconv_group_scheduler_pkg.sv
// Shared NPU scheduler definitions: state encoding and default sizing.
// The depthwise group scheduler and the reusable watchdog both use this package.
package dwconv_group_scheduler_pkg;

  localparam int NPU_GROUP_W        = 16;
  localparam int NPU_TIMEOUT_CYCLES = 4096;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_START       = 3'd1,
    ST_WAIT_FEAT   = 3'd2,
    ST_WAIT_PE     = 3'd3,
    ST_WAIT_WEIGHT = 3'd4,
    ST_RELEASE     = 3'd5,
    ST_DONE        = 3'd6
  } sched_state_e;

  // States that block on an external responder and are guarded by the watchdog.
  function automatic logic is_wait_state(input sched_state_e s);
    return (s == ST_WAIT_FEAT) || (s == ST_WAIT_PE) || (s == ST_WAIT_WEIGHT);
  endfunction

endpackage

// File: rtl/npu_watchdog.sv
// Cycle watchdog shared by the NPU schedulers: counts while enabled and flags
// expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
module npu_watchdog
  import dwconv_group_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = NPU_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_eff;

  // clear marks the first cycle of a new state, so that cycle counts from zero.
  assign cnt_eff = clear ? '0 : cnt_q;
  assign expire  = count_en && (cnt_eff == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (count_en && !expire) begin
      cnt_q <= cnt_eff + CW'(1);
    end else begin
      cnt_q <= cnt_eff;
    end
  end

endmodule

// File: rtl/dwconv_group_scheduler.sv
// Depthwise-convolution layer sequencer: walks each feature group through
// fetch, PE accumulation and weight reload, with a watchdog on every wait.
module dwconv_group_scheduler
  import dwconv_group_scheduler_pkg::*;
#(
  parameter int GROUP_W        = NPU_GROUP_W,
  parameter int TIMEOUT_CYCLES = NPU_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_layer_start,
  input  logic [GROUP_W-1:0] i_total_groups,
  input  logic               i_feature_end,
  input  logic               i_pe_done,
  input  logic               i_weight_ready,
  output logic               o_start_calculate,
  output logic               o_weight_load_end,
  output logic               o_weight_load_req,
  output logic               o_pe_start,
  output logic               o_busy,
  output logic               o_layer_done,
  output logic [GROUP_W-1:0] o_group_cnt,
  output logic               o_err,
  output sched_state_e       o_dbg_state
);

  // Handshake: every request/acknowledge here is a single-cycle pulse, except
  // i_weight_ready which is a level; a pulse counts only in the state that
  // waits for it, and each output pulse is high for exactly one cycle.
  sched_state_e       state;
  sched_state_e       prev_state;
  logic [GROUP_W-1:0] total_q;
  logic [GROUP_W-1:0] group_cnt_q;
  logic               err_q;
  logic               pe_start_q;
  logic               wl_req_q;

  logic wd_clear;
  logic wd_count_en;
  logic wd_expire;
  logic feat_spurious;
  logic pe_spurious;

  assign wd_clear      = (state != prev_state);
  assign wd_count_en   = is_wait_state(state);
  assign feat_spurious = i_feature_end && (state != ST_WAIT_FEAT);
  assign pe_spurious   = i_pe_done && (state != ST_WAIT_PE);

  npu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .count_en(wd_count_en),
    .expire  (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      prev_state  <= ST_IDLE;
      total_q     <= '0;
      group_cnt_q <= '0;
      err_q       <= 1'b0;
      pe_start_q  <= 1'b0;
      wl_req_q    <= 1'b0;
    end else begin
      prev_state <= state;
      pe_start_q <= 1'b0;
      wl_req_q   <= 1'b0;
      // Errors are recorded independently of whatever transition is taken.
      if (feat_spurious || pe_spurious || wd_expire) begin
        err_q <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (i_layer_start) begin
            total_q     <= i_total_groups;
            group_cnt_q <= '0;
            err_q       <= feat_spurious || pe_spurious;
            state       <= (i_total_groups == '0) ? ST_DONE : ST_START;
          end
        end
        ST_START: begin
          state <= ST_WAIT_FEAT;
        end
        ST_WAIT_FEAT: begin
          if (i_feature_end) begin
            group_cnt_q <= group_cnt_q + GROUP_W'(1);
            pe_start_q  <= 1'b1;
            state       <= ST_WAIT_PE;
          end else if (wd_expire) begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT_PE: begin
          if (i_pe_done) begin
            if (group_cnt_q == total_q) begin
              state <= ST_DONE;
            end else begin
              wl_req_q <= 1'b1;
              state    <= ST_WAIT_WEIGHT;
            end
          end else if (wd_expire) begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT_WEIGHT: begin
          if (i_weight_ready) begin
            state <= ST_RELEASE;
          end else if (wd_expire) begin
            state <= ST_IDLE;
          end
        end
        ST_RELEASE: begin
          state <= ST_WAIT_FEAT;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_start_calculate = (state == ST_START);
  assign o_weight_load_end = (state == ST_RELEASE);
  assign o_layer_done      = (state == ST_DONE);
  assign o_busy            = (state != ST_IDLE);
  assign o_pe_start        = pe_start_q;
  assign o_weight_load_req = wl_req_q;
  assign o_group_cnt       = group_cnt_q;
  assign o_err             = err_q;
  assign o_dbg_state       = state;

endmodule

// File: tb/tb_dwconv_group_scheduler.sv
// Scoreboard bench for dwconv_group_scheduler: each output pulse is matched
// against a queue of hand-timed events {pulses, group count, err, cycle gap}.
module tb_dwconv_group_scheduler;
  import dwconv_group_scheduler_pkg::*;

  localparam int GW = 4;
  localparam int TO = 16;
  localparam int EW = 5 + GW + 1 + 8;

  localparam logic [4:0] P_SC   = 5'b10000;
  localparam logic [4:0] P_PE   = 5'b01000;
  localparam logic [4:0] P_REQ  = 5'b00100;
  localparam logic [4:0] P_END  = 5'b00010;
  localparam logic [4:0] P_DONE = 5'b00001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_layer_start = 1'b0;
  logic [GW-1:0] i_total_groups = '0;
  logic          i_feature_end = 1'b0;
  logic          i_pe_done = 1'b0;
  logic          i_weight_ready = 1'b0;
  logic          o_start_calculate;
  logic          o_weight_load_end;
  logic          o_weight_load_req;
  logic          o_pe_start;
  logic          o_busy;
  logic          o_layer_done;
  logic [GW-1:0] o_group_cnt;
  logic          o_err;
  sched_state_e  o_dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];

  bit fe_en     = 1'b1;
  bit pe_en     = 1'b1;
  bit spur_en   = 1'b0;
  bit wr_always = 1'b0;
  int cycle     = 0;
  int ref_cycle = 0;

  dwconv_group_scheduler #(
    .GROUP_W(GW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_layer_start    (i_layer_start),
    .i_total_groups   (i_total_groups),
    .i_feature_end    (i_feature_end),
    .i_pe_done        (i_pe_done),
    .i_weight_ready   (i_weight_ready),
    .o_start_calculate(o_start_calculate),
    .o_weight_load_end(o_weight_load_end),
    .o_weight_load_req(o_weight_load_req),
    .o_pe_start       (o_pe_start),
    .o_busy           (o_busy),
    .o_layer_done     (o_layer_done),
    .o_group_cnt      (o_group_cnt),
    .o_err            (o_err),
    .o_dbg_state      (o_dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin : global_guard
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got %0d of %0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic push(input logic [4:0] pulses, input int cnt, input logic err, input int dt);
    exp_q.push_back({pulses, GW'(cnt), err, 8'(dt)});
  endtask

  // Driver tasks
  task automatic start_layer(input int total);
    @(posedge clk); #1;
    i_total_groups = GW'(total);
    i_layer_start  = 1'b1;
    @(posedge clk); #1;
    i_layer_start  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_layer_done !== 1'b1 && n < budget);
    check({name, "_layer_done"}, 32'(o_layer_done), 32'd1);
  endtask

  task automatic idle_checks(input string name, input int cnt, input logic err);
    @(negedge clk);
    check({name, "_busy"},  32'(o_busy), 32'd0);
    check({name, "_state"}, 32'(o_dbg_state), 32'(ST_IDLE));
    check({name, "_cnt"},   32'(o_group_cnt), 32'(cnt));
    check({name, "_err"},   32'(o_err), 32'(err));
  endtask

  task automatic zero_checks(input string name);
    check({name, "_pulses"}, 32'({o_start_calculate, o_pe_start, o_weight_load_req,
                                  o_weight_load_end, o_layer_done}), 32'd0);
    check({name, "_busy"}, 32'(o_busy), 32'd0);
    check({name, "_cnt"},  32'(o_group_cnt), 32'd0);
    check({name, "_err"},  32'(o_err), 32'd0);
  endtask

  // Responder models: IAGU fetch 3 cycles after a start/release, PE done
  // 5 cycles after pe_start, WAGU ready 2 cycles after a load request.
  initial begin : iagu_model
    forever begin
      @(negedge clk);
      if (fe_en && (o_start_calculate === 1'b1 || o_weight_load_end === 1'b1)) begin
        repeat (3) @(posedge clk);
        #1 i_feature_end = 1'b1;
        @(posedge clk);
        #1 i_feature_end = 1'b0;
        if (spur_en) begin
          @(posedge clk);
          #1 i_feature_end = 1'b1;
          @(posedge clk);
          #1 i_feature_end = 1'b0;
        end
      end
    end
  end

  initial begin : pe_model
    forever begin
      @(negedge clk);
      if (o_pe_start === 1'b1) begin
        repeat (5) @(posedge clk);
        #1 if (pe_en) i_pe_done = 1'b1;
        @(posedge clk);
        #1 i_pe_done = 1'b0;
      end
    end
  end

  initial begin : wagu_model
    forever begin
      @(negedge clk);
      if (wr_always) begin
        i_weight_ready = 1'b1;
      end else begin
        i_weight_ready = 1'b0;
        if (o_weight_load_req === 1'b1) begin
          repeat (2) @(posedge clk);
          #1 i_weight_ready = 1'b1;
          @(posedge clk);
          #1 i_weight_ready = 1'b0;
        end
      end
    end
  end

  // Monitor: every cycle with any pulse output pops one expected event.
  initial begin : monitor
    logic [4:0]    pulses;
    logic [EW-1:0] act;
    logic [EW-1:0] exp;
    forever begin
      @(negedge clk);
      cycle++;
      if (i_layer_start === 1'b1) ref_cycle = cycle;
      pulses = {o_start_calculate, o_pe_start, o_weight_load_req, o_weight_load_end, o_layer_done};
      if ((|pulses) === 1'b1) begin
        act = {pulses, o_group_cnt, o_err, 8'(cycle - ref_cycle)};
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL event_unexpected: got pulses=%b cnt=%0d err=%b dt=%0d, expected no event",
                   act[EW-1 -: 5], act[8+GW:9], act[8], act[7:0]);
        end else begin
          exp = exp_q.pop_front();
          if (act === exp) n_pass++;
          else $display("FAIL event: got pulses=%b cnt=%0d err=%b dt=%0d, expected pulses=%b cnt=%0d err=%b dt=%0d",
                        act[EW-1 -: 5], act[8+GW:9], act[8], act[7:0],
                        exp[EW-1 -: 5], exp[8+GW:9], exp[8], exp[7:0]);
        end
        ref_cycle = cycle;
      end
    end
  end

  initial begin : main
    int n;
    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    zero_checks("reset");
    check("reset_state", 32'(o_dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1 rst = 1'b0;

    // Three groups, ideal responders
    push(P_SC, 0, 0, 1);
    push(P_PE, 1, 0, 4); push(P_REQ, 1, 0, 6); push(P_END, 1, 0, 3);
    push(P_PE, 2, 0, 4); push(P_REQ, 2, 0, 6); push(P_END, 2, 0, 3);
    push(P_PE, 3, 0, 4); push(P_DONE, 3, 0, 6);
    start_layer(3);
    wait_done("t3grp", 200);
    check("t3grp_busy_in_done", 32'(o_busy), 32'd1);
    idle_checks("t3grp", 3, 1'b0);

    // Zero groups: done right after the start
    push(P_DONE, 0, 0, 1);
    start_layer(0);
    wait_done("t0grp", 4);
    idle_checks("t0grp", 0, 1'b0);

    // Weight ready held high: load_end two cycles after pe_done
    wr_always = 1'b1;
    push(P_SC, 0, 0, 1);
    push(P_PE, 1, 0, 4); push(P_REQ, 1, 0, 6); push(P_END, 1, 0, 1);
    push(P_PE, 2, 0, 4); push(P_DONE, 2, 0, 6);
    start_layer(2);
    wait_done("tready", 200);
    idle_checks("tready", 2, 1'b0);
    wr_always = 1'b0;
    repeat (2) @(posedge clk);

    // Spurious feature_end while waiting on the PE
    spur_en = 1'b1;
    push(P_SC, 0, 0, 1);
    push(P_PE, 1, 0, 4); push(P_REQ, 1, 1, 6); push(P_END, 1, 1, 3);
    push(P_PE, 2, 1, 4); push(P_DONE, 2, 1, 6);
    start_layer(2);
    wait_done("tspur", 200);
    idle_checks("tspur", 2, 1'b1);
    spur_en = 1'b0;

    // Watchdog: no feature_end ever arrives
    fe_en = 1'b0;
    push(P_SC, 0, 0, 1);
    start_layer(1);
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("tto_busy_before", 32'(o_busy), 32'd1);
    check("tto_err_before",  32'(o_err), 32'd0);
    check("tto_state_before", 32'(o_dbg_state), 32'(ST_WAIT_FEAT));
    @(negedge clk);
    check("tto_busy_after", 32'(o_busy), 32'd0);
    check("tto_err_after",  32'(o_err), 32'd1);
    repeat (4) @(negedge clk);
    check("tto_err_sticky", 32'(o_err), 32'd1);
    fe_en = 1'b1;

    // Reset while waiting on the PE, then a clean single-group layer
    push(P_SC, 0, 0, 1);
    push(P_PE, 1, 0, 4);
    start_layer(3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_pe_start !== 1'b1 && n < 50);
    check("trst_pe_start_seen", 32'(o_pe_start), 32'd1);
    pe_en = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    zero_checks("trst_after");
    repeat (6) @(posedge clk);
    pe_en = 1'b1;
    push(P_SC, 0, 0, 1);
    push(P_PE, 1, 0, 4); push(P_DONE, 1, 0, 6);
    start_layer(1);
    wait_done("trst_new", 100);
    idle_checks("trst_new", 1, 1'b0);

    // Largest legal total for a 4-bit counter
    push(P_SC, 0, 0, 1);
    for (int g = 1; g <= 15; g++) begin
      push(P_PE, g, 0, 4);
      if (g < 15) begin
        push(P_REQ, g, 0, 6);
        push(P_END, g, 0, 3);
      end else begin
        push(P_DONE, g, 0, 6);
      end
    end
    start_layer(15);
    wait_done("tmax", 400);
    idle_checks("tmax", 15, 1'b0);

    repeat (10) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dwconv_group_scheduler.md
DWCONV_GROUP_SCHEDULER -- requirements
Module: dwconv_group_scheduler

Interface
REQ-001 SHALL have parameter GROUP_W, default 16, width of the group counters.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, the wait-state watchdog limit.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_layer_start  input  1  one-cycle pulse from the decoder that starts a depthwise layer.
REQ-006 SHALL have port i_total_groups  input  GROUP_W  the number of feature groups in the layer; sampled on an accepted i_layer_start.
REQ-007 SHALL have port i_feature_end  input  1  pulse from the depthwise IAGU: one group has been fetched.
REQ-008 SHALL have port i_pe_done  input  1  pulse from the PE array: group accumulation is complete.
REQ-009 SHALL have port i_weight_ready  input  1  level from the WAGU: the next weights are loaded.
REQ-010 SHALL have port o_start_calculate  output  1  one-cycle pulse to the IAGU.
REQ-011 SHALL have port o_weight_load_end  output  1  one-cycle pulse to the IAGU that releases its group wait.
REQ-012 SHALL have port o_weight_load_req  output  1  one-cycle pulse to the WAGU.
REQ-013 SHALL have port o_pe_start  output  1  one-cycle pulse to the PE array.
REQ-014 SHALL have port o_busy  output  1  high whenever the state is not IDLE.
REQ-015 SHALL have port o_layer_done  output  1  one-cycle pulse at the end of the layer.
REQ-016 SHALL have port o_group_cnt  output  GROUP_W  the number of groups completed so far.
REQ-017 SHALL have port o_err  output  1  sticky protocol/timeout error flag.

Function
REQ-018 SHALL implement states IDLE, START, WAIT_FEAT, WAIT_PE, WAIT_WEIGHT, RELEASE, DONE in one registered FSM.
REQ-019 SHALL decode all pulse outputs from the registered state (o_start_calculate=START, o_weight_load_end=RELEASE, o_layer_done=DONE) or from registered flags, with no combinational path from any input to any output.
REQ-020 IDLE: on i_layer_start, SHALL latch i_total_groups, clear o_group_cnt and o_err, then go to DONE if the latched value is 0, else to START.
REQ-021 START SHALL last exactly one cycle and then go to WAIT_FEAT; o_start_calculate is therefore high in the cycle after i_layer_start is sampled.
REQ-022 WAIT_FEAT: on i_feature_end, SHALL go to WAIT_PE, increment o_group_cnt by 1, and pulse o_pe_start in the following cycle.
REQ-023 WAIT_PE: on i_pe_done, SHALL go to DONE if o_group_cnt equals the latched total; otherwise SHALL pulse o_weight_load_req once and go to WAIT_WEIGHT.
REQ-024 WAIT_WEIGHT: when i_weight_ready is high, SHALL go to RELEASE; this includes i_weight_ready already high on entry, giving one cycle of dwell.
REQ-025 RELEASE SHALL last exactly one cycle and then go to WAIT_FEAT.
REQ-026 DONE SHALL last exactly one cycle and then go to IDLE.
REQ-027 SHALL ignore i_layer_start in every state except IDLE, with no error.
REQ-028 i_feature_end outside WAIT_FEAT, or i_pe_done outside WAIT_PE, SHALL set o_err, be otherwise ignored, and leave the state unchanged.
REQ-029 Watchdog: a counter SHALL clear on every state change and count cycles while in WAIT_FEAT, WAIT_PE or WAIT_WEIGHT.
REQ-030 When the watchdog reaches TIMEOUT_CYCLES-1, SHALL set o_err and go to IDLE without asserting o_layer_done.
REQ-031 o_group_cnt SHALL NOT wrap, because the terminal compare stops the layer first; a latched total of 2^GROUP_W-1 SHALL be legal.
REQ-032 o_err SHALL hold until reset or the next accepted i_layer_start.
REQ-033 If an error event and a transition-causing input occur in the same cycle, SHALL set o_err and still take the transition.

Reset
REQ-034 While rst is high on a clock edge, SHALL go to IDLE and clear the watchdog, the latched total, o_group_cnt and o_err to 0.
REQ-035 All outputs SHALL be 0 in the cycle after a reset edge.
REQ-036 A reset mid-layer SHALL abandon the layer, with no o_layer_done pulse.

Structure
REQ-037 SHALL take the state encoding (3 bits) and the default values of GROUP_W and TIMEOUT_CYCLES from the shared NPU package.
REQ-038 SHALL place the watchdog in one sub-module, npu_watchdog (inputs clear and count enable, output expire), for reuse by other schedulers.

Verification
REQ-039 total=3, ideal responders (pe_done 5 cycles after pe_start, weight_ready 2 cycles after req) -> exactly 1 start_calculate, 3 pe_start, 2 weight_load_req, 2 weight_load_end, 1 layer_done; o_group_cnt=3; o_err=0.
REQ-040 total=0 -> o_layer_done high in the cycle after i_layer_start; no other pulses.
REQ-041 i_weight_ready held high throughout, total=2 -> o_weight_load_end exactly 2 cycles after the first i_pe_done.
REQ-042 Spurious i_feature_end during WAIT_PE, total=2 -> o_err=1, o_group_cnt=2 at done, layer completes normally.
REQ-043 TIMEOUT_CYCLES=16, no i_feature_end -> o_err=1 and o_busy=0 after 16 cycles in WAIT_FEAT; no layer_done pulse.
REQ-044 rst asserted in WAIT_PE, then a new layer with total=1 -> clean restart, o_group_cnt=1, o_err=0.
